// File: rtl/mc_config_loader.sv
// Macrocell configuration loader: shifts a serial fuse stream into a shadow
// register, commits it atomically to the mux-select outputs, and reads it back.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for load_start / rd_start
// LOAD   | accepting sdi bits into the shadow register
// COMMIT | one cycle: copy shadow into the active configuration
// READ   | presenting active configuration on sdo, one bit per handshake
module mc_config_loader #(
  parameter int   PT_BITS    = 480,
  parameter int   CFG_BITS   = 501,
  parameter logic ERASED_VAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               rd_start,
  input  logic               abort,
  input  logic               sdi,
  input  logic               sdi_valid,
  output logic               sdi_ready,
  output logic               sdo,
  output logic               sdo_valid,
  input  logic               sdo_ready,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [0:PT_BITS-1] ptgroupbitmap_mux,
  output logic [0:2]         oe_mux,
  output logic [0:1]         gclk_mux,
  output logic               pt1_mux,
  output logic               pt2_mux,
  output logic               pt3_mux,
  output logic               pt4_mux,
  output logic               pt5_mux,
  output logic               gclr_mux,
  output logic               pt4_func_mux,
  output logic               pt5_func_mux,
  output logic               xor_a_mux,
  output logic               xor_b_mux,
  output logic               xor_inv_mux,
  output logic               d_mux,
  output logic               dfast_mux,
  output logic               storage_mux,
  output logic               fb_mux,
  output logic               o_mux
);

  localparam logic [8:0] LAST = 9'(CFG_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_READ
  } state_t;

  state_t                state;
  logic [8:0]            cnt;
  logic [8:0]            cnt_nxt;
  logic [0:CFG_BITS-1]   shadow_q;
  logic [0:CFG_BITS-1]   active_q;
  logic                  done_q;
  logic                  rd_last;

  assign cnt_nxt = cnt + 9'd1;

  // Final readback transfer flags done in the same cycle it happens; abort wins.
  assign rd_last = (state == S_READ) && sdo_valid && sdo_ready && !abort && (cnt == LAST);
  assign done    = done_q | rd_last;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shadow_q  <= {CFG_BITS{ERASED_VAL}};
      active_q  <= {CFG_BITS{ERASED_VAL}};
      sdi_ready <= 1'b0;
      sdo_valid <= 1'b0;
      sdo       <= 1'b0;
      done_q    <= 1'b0;
      err       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            state     <= S_LOAD;
            cnt       <= '0;
            sdi_ready <= 1'b1;
          end else if (rd_start) begin
            state     <= S_READ;
            cnt       <= '0;
            sdo_valid <= 1'b1;
            sdo       <= active_q[0];
          end
        end
        S_LOAD: begin
          if (abort) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sdi_ready <= 1'b0;
            err       <= 1'b1;
            shadow_q  <= {CFG_BITS{ERASED_VAL}};
          end else if (sdi_valid) begin
            shadow_q[cnt] <= sdi;
            if (cnt == LAST) begin
              state     <= S_COMMIT;
              sdi_ready <= 1'b0;
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        S_COMMIT: begin
          active_q <= shadow_q;
          done_q   <= 1'b1;
          cnt      <= '0;
          state    <= S_IDLE;
        end
        S_READ: begin
          if (abort) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sdo_valid <= 1'b0;
            sdo       <= 1'b0;
            err       <= 1'b1;
          end else if (sdo_ready) begin
            if (cnt == LAST) begin
              state     <= S_IDLE;
              cnt       <= '0;
              sdo_valid <= 1'b0;
              sdo       <= 1'b0;
            end else begin
              cnt <= cnt_nxt;
              sdo <= active_q[cnt_nxt];
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          cnt       <= '0;
          sdi_ready <= 1'b0;
          sdo_valid <= 1'b0;
          sdo       <= 1'b0;
        end
      endcase
    end
  end

  // Stream order: PT bitmap, OE, GCLK, then the sixteen single selects.
  assign ptgroupbitmap_mux = active_q[0:PT_BITS-1];
  assign oe_mux            = active_q[PT_BITS +: 3];
  assign gclk_mux          = active_q[PT_BITS+3 +: 2];
  assign {pt1_mux, pt2_mux, pt3_mux, pt4_mux, pt5_mux, gclr_mux,
          pt4_func_mux, pt5_func_mux, xor_a_mux, xor_b_mux, xor_inv_mux,
          d_mux, dfast_mux, storage_mux, fb_mux, o_mux} = active_q[PT_BITS+5 +: 16];

endmodule

// File: tb/tb_mc_config_loader.sv
// Directed bench for mc_config_loader: table-driven output probes plus
// hand-written load, abort and readback sequences.
module tb_mc_config_loader;

  localparam int CFG = 501;

  logic clk, rst, load_start, rd_start, abort, sdi, sdi_valid, sdi_ready;
  logic sdo, sdo_valid, sdo_ready, busy, done, err;
  logic [0:479] ptgroupbitmap_mux;
  logic [0:2]   oe_mux;
  logic [0:1]   gclk_mux;
  logic pt1_mux, pt2_mux, pt3_mux, pt4_mux, pt5_mux, gclr_mux, pt4_func_mux, pt5_func_mux;
  logic xor_a_mux, xor_b_mux, xor_inv_mux, d_mux, dfast_mux, storage_mux, fb_mux, o_mux;

  int n_pass  = 0;
  int n_total = 0;
  logic [0:CFG-1] model_cfg;
  logic [0:CFG-1] pat_a, pat_b;

  typedef struct {
    int   id;
    logic exp_a;
    logic exp_b;
  } probe_t;
  probe_t tbl[14];

  mc_config_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .rd_start(rd_start), .abort(abort),
    .sdi(sdi), .sdi_valid(sdi_valid), .sdi_ready(sdi_ready),
    .sdo(sdo), .sdo_valid(sdo_valid), .sdo_ready(sdo_ready),
    .busy(busy), .done(done), .err(err),
    .ptgroupbitmap_mux(ptgroupbitmap_mux), .oe_mux(oe_mux), .gclk_mux(gclk_mux),
    .pt1_mux(pt1_mux), .pt2_mux(pt2_mux), .pt3_mux(pt3_mux), .pt4_mux(pt4_mux),
    .pt5_mux(pt5_mux), .gclr_mux(gclr_mux), .pt4_func_mux(pt4_func_mux),
    .pt5_func_mux(pt5_func_mux), .xor_a_mux(xor_a_mux), .xor_b_mux(xor_b_mux),
    .xor_inv_mux(xor_inv_mux), .d_mux(d_mux), .dfast_mux(dfast_mux),
    .storage_mux(storage_mux), .fb_mux(fb_mux), .o_mux(o_mux)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [0:CFG-1] get_cfg();
    logic [0:CFG-1] v;
    v[0:479]   = ptgroupbitmap_mux;
    v[480:482] = oe_mux;
    v[483:484] = gclk_mux;
    v[485:500] = {pt1_mux, pt2_mux, pt3_mux, pt4_mux, pt5_mux, gclr_mux, pt4_func_mux,
                  pt5_func_mux, xor_a_mux, xor_b_mux, xor_inv_mux, d_mux, dfast_mux,
                  storage_mux, fb_mux, o_mux};
    return v;
  endfunction

  function automatic logic probe(input int id);
    case (id)
      0:  return ptgroupbitmap_mux[0];
      1:  return ptgroupbitmap_mux[1];
      2:  return ptgroupbitmap_mux[479];
      3:  return oe_mux[0];
      4:  return oe_mux[1];
      5:  return oe_mux[2];
      6:  return gclk_mux[0];
      7:  return gclk_mux[1];
      8:  return pt1_mux;
      9:  return gclr_mux;
      10: return xor_inv_mux;
      11: return o_mux;
      12: return dfast_mux;
      13: return pt4_func_mux;
      default: return 1'bx;
    endcase
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_vec(input string name, input logic [0:CFG-1] act, input logic [0:CFG-1] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_table(input bit use_b);
    for (int i = 0; i < 14; i++)
      chk_bit($sformatf("probe%0d_%s", tbl[i].id, use_b ? "b" : "a"), probe(tbl[i].id),
              use_b ? tbl[i].exp_b : tbl[i].exp_a);
  endtask

  task automatic do_load(input string tag, input logic [0:CFG-1] s, input bit toggle,
                         input int abort_at, input int exp_cycles);
    int idx, cyc;
    bit hold_ok, aborted;
    logic rdy;
    logic [2:0] dpat;
    logic [0:CFG-1] old;
    old = model_cfg; idx = 0; cyc = 0; hold_ok = 1'b1; aborted = 1'b0;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    while (idx < CFG && !aborted && cyc < 4000) begin
      sdi_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      sdi       = sdi_valid ? s[idx] : ~s[idx];
      abort     = (idx == abort_at);
      @(negedge clk);
      rdy = sdi_ready;
      if (!rdy || done || err || !busy || get_cfg() !== old) hold_ok = 1'b0;
      @(posedge clk); #1;
      if (abort) aborted = 1'b1;
      else if (sdi_valid && rdy) idx++;
      cyc++;
    end
    sdi_valid = 1'b0; sdi = 1'b0; abort = 1'b0;
    chk_bit({tag, "_hold_during_load"}, hold_ok, 1'b1);
    if (abort_at >= 0) begin
      @(negedge clk);
      chk_bit({tag, "_err_pulse"}, err, 1'b1);
      chk_bit({tag, "_busy_after_abort"}, busy, 1'b0);
      chk_bit({tag, "_ready_after_abort"}, sdi_ready, 1'b0);
      chk_vec({tag, "_cfg_after_abort"}, get_cfg(), old);
      @(negedge clk);
      chk_bit({tag, "_err_one_cycle"}, err, 1'b0);
    end else begin
      chk_int({tag, "_cycles"}, cyc, exp_cycles);
      dpat = '0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        dpat[2-k] = done;
        if (k == 0) begin
          chk_bit({tag, "_ready_drop"}, sdi_ready, 1'b0);
          chk_vec({tag, "_cfg_in_commit"}, get_cfg(), old);
        end
        if (k == 1) chk_vec({tag, "_cfg_committed"}, get_cfg(), s);
      end
      chk_int({tag, "_done_pattern"}, int'(dpat), 2);
      model_cfg = s;
    end
  endtask

  task automatic do_read(input string tag, input logic [0:CFG-1] exp);
    logic [0:CFG-1] got;
    int n, cyc, dn;
    bit dn_ok;
    logic v, o, d;
    got = '0; n = 0; cyc = 0; dn = 0; dn_ok = 1'b1;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    while (n < CFG && cyc < 5000) begin
      sdo_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      v = sdo_valid; o = sdo; d = done;
      if (d) begin
        dn++;
        if (!(v && sdo_ready && n == CFG - 1)) dn_ok = 1'b0;
      end
      if (v && sdo_ready) begin
        got[n] = o;
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    sdo_ready = 1'b0;
    chk_int({tag, "_rd_count"}, n, CFG);
    chk_vec({tag, "_rd_stream"}, got, exp);
    chk_int({tag, "_rd_done_count"}, dn, 1);
    chk_bit({tag, "_rd_done_timing"}, dn_ok, 1'b1);
    @(negedge clk);
    chk_bit({tag, "_rd_valid_drop"}, sdo_valid, 1'b0);
    chk_bit({tag, "_rd_idle"}, busy, 1'b0);
    chk_vec({tag, "_rd_cfg_unchanged"}, get_cfg(), model_cfg);
  endtask

  initial begin
    tbl[0]  = '{0, 1'b0, 1'b1};   // pt[0]
    tbl[1]  = '{1, 1'b1, 1'b0};   // pt[1]
    tbl[2]  = '{2, 1'b1, 1'b0};   // pt[479]
    tbl[3]  = '{3, 1'b0, 1'b1};   // oe[0]   stream 480
    tbl[4]  = '{4, 1'b1, 1'b0};   // oe[1]   481
    tbl[5]  = '{5, 1'b0, 1'b0};   // oe[2]   482
    tbl[6]  = '{6, 1'b1, 1'b1};   // gclk[0] 483
    tbl[7]  = '{7, 1'b0, 1'b0};   // gclk[1] 484
    tbl[8]  = '{8, 1'b1, 1'b0};   // pt1     485
    tbl[9]  = '{9, 1'b0, 1'b0};   // gclr    490
    tbl[10] = '{10, 1'b1, 1'b1};  // xor_inv 495
    tbl[11] = '{11, 1'b0, 1'b0};  // o       500
    tbl[12] = '{12, 1'b1, 1'b0};  // dfast   497
    tbl[13] = '{13, 1'b1, 1'b0};  // pt4_func 491

    for (int i = 0; i < CFG; i++) begin
      pat_a[i] = (i % 2 == 1);
      pat_b[i] = (i % 3 == 0);
    end
    model_cfg = {CFG{1'b1}};

    rst = 1'b1; load_start = 1'b0; rd_start = 1'b0; abort = 1'b0;
    sdi = 1'b0; sdi_valid = 1'b0; sdo_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_vec("reset_cfg", get_cfg(), {CFG{1'b1}});
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_sdi_ready", sdi_ready, 1'b0);
    chk_bit("reset_sdo_valid", sdo_valid, 1'b0);
    chk_bit("reset_sdo", sdo, 1'b0);
    chk_bit("reset_done", done, 1'b0);
    chk_bit("reset_err", err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // abort while idle is ignored
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk_bit("idle_abort_err", err, 1'b0);
    chk_bit("idle_abort_busy", busy, 1'b0);

    // simultaneous starts: load wins; rd_start during LOAD ignored
    @(posedge clk); #1;
    load_start = 1'b1; rd_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0; rd_start = 1'b0;
    @(negedge clk);
    chk_bit("both_start_sdi_ready", sdi_ready, 1'b1);
    chk_bit("both_start_sdo_valid", sdo_valid, 1'b0);
    @(posedge clk); #1;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    @(negedge clk);
    chk_bit("rd_in_load_sdi_ready", sdi_ready, 1'b1);
    chk_bit("rd_in_load_sdo_valid", sdo_valid, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk_bit("both_start_abort_err", err, 1'b1);
    chk_vec("both_start_cfg_erased", get_cfg(), {CFG{1'b1}});
    @(posedge clk); #1;

    do_load("load_a", pat_a, 1'b0, -1, CFG);
    check_table(1'b0);
    do_read("read_a", pat_a);

    @(posedge clk); #1;
    do_load("abort_b", pat_b, 1'b0, 200, 0);
    chk_vec("abort_keeps_a", get_cfg(), pat_a);

    @(posedge clk); #1;
    do_load("load_b_toggle", pat_b, 1'b1, -1, 2 * CFG - 1);
    check_table(1'b1);
    do_read("read_b", pat_b);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
